// File: rtl/tx_redundant_framer_if.sv
// Interface bundle for tx_redundant_framer.
// Groups the start/status handshake, the frame-buffer read port and the
// GMII-style byte stream.
//   start       : one-cycle job request (controller -> framer)
//   redundancy  : replica count sampled with an accepted start
//   rd_seg      : segment index of the buffer read (framer -> buffer)
//   rd_idx      : byte index of the buffer read (framer -> buffer)
//   rd_data     : buffer byte, one cycle after rd_seg/rd_idx
//   tx_en       : frame byte valid
//   tx_data     : frame byte
//   busy        : job in progress
//   done        : one-cycle pulse at job completion
//   aux         : sequence byte carried by every frame of the current job
// Modport slave is the framer; modport master is the controller/buffer side.
interface tx_redundant_framer_if;
  logic        start;
  logic [7:0]  redundancy;
  logic [15:0] rd_seg;
  logic [15:0] rd_idx;
  logic [7:0]  rd_data;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic [7:0]  aux;

  modport master (
    output start, redundancy, rd_data,
    input  rd_seg, rd_idx, tx_en, tx_data, busy, done, aux
  );

  modport slave (
    input  start, redundancy, rd_data,
    output rd_seg, rd_idx, tx_en, tx_data, busy, done, aux
  );
endinterface

// File: rtl/tx_redundant_framer.sv
// Redundant transmit framer.
// On an accepted start, sends every segment (0..SEGMENT_NUM_MAX-1) once per
// replica id (1..R) as fixed-length byte frames. Four bytes at
// WHEREIS_SEGMENT_NUM carry seg[15:8], seg[7:0], id and aux; every other byte
// comes from the upstream frame buffer.
// Ports:
//   clk125MHz : single clock
//   reset     : synchronous, active-low
//   bus       : tx_redundant_framer_if.slave (start/redundancy in, buffer
//               read port, tx_en/tx_data stream, busy/done/aux status)
module tx_redundant_framer #(
  parameter int PACKET_SIZE         = 577,
  parameter int WHEREIS_SEGMENT_NUM = 34,
  parameter int SEGMENT_NUM_MAX     = 5,
  parameter int IFG                 = 10,
  parameter int ROUND_GAP           = 30
) (
  input  logic                 clk125MHz,
  input  logic                 reset,
  tx_redundant_framer_if.slave bus
);
  localparam int          DATA_W     = 8;
  localparam logic [15:0] LAST_BYTE  = 16'(PACKET_SIZE - 1);
  localparam logic [15:0] OFS_SEG_HI = 16'(WHEREIS_SEGMENT_NUM);
  localparam logic [15:0] OFS_SEG_LO = 16'(WHEREIS_SEGMENT_NUM + 1);
  localparam logic [15:0] OFS_ID     = 16'(WHEREIS_SEGMENT_NUM + 2);
  localparam logic [15:0] OFS_AUX    = 16'(WHEREIS_SEGMENT_NUM + 3);
  localparam logic [15:0] LAST_SEG   = 16'(SEGMENT_NUM_MAX - 1);
  localparam logic [7:0]  IFG_LAST   = 8'(IFG - 1);
  localparam logic [7:0]  RGAP_LAST  = 8'(ROUND_GAP - 1);

  typedef enum logic [2:0] {IDLE, FETCH, SEND, GAP, RGAP} state_t;

  // Field insertion: the four voting fields override the buffer byte.
  function automatic logic [DATA_W-1:0] frame_byte(
    input logic [15:0]       idx,
    input logic [15:0]       seg_num,
    input logic [7:0]        id_num,
    input logic [7:0]        aux_num,
    input logic [DATA_W-1:0] buf_byte
  );
    logic [DATA_W-1:0] b;
    b = buf_byte;
    if (idx == OFS_SEG_HI)      b = seg_num[15:8];
    else if (idx == OFS_SEG_LO) b = seg_num[7:0];
    else if (idx == OFS_ID)     b = id_num;
    else if (idx == OFS_AUX)    b = aux_num;
    return b;
  endfunction

  state_t            state, state_nxt;
  logic [15:0]       byte_cnt, byte_cnt_nxt;
  logic [7:0]        gap_cnt, gap_cnt_nxt;
  logic [15:0]       seg, seg_nxt;
  logic [7:0]        id, id_nxt;
  logic [7:0]        rep, rep_nxt;
  logic              fin, fin_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic [7:0]        aux_q, aux_nxt;
  logic [15:0]       rd_seg_c, rd_idx_c;
  logic              vld_p0, vld_p1;
  logic [DATA_W-1:0] data_p0, data_p1;

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    seg_nxt      = seg;
    id_nxt       = id;
    rep_nxt      = rep;
    fin_nxt      = fin;
    busy_nxt     = busy_q;
    done_nxt     = 1'b0;
    aux_nxt      = aux_q;
    rd_seg_c     = '0;
    rd_idx_c     = '0;
    vld_p0       = 1'b0;
    data_p0      = '0;
    case (state)
      IDLE: begin
        // done_q blocks a start arriving in the completion cycle.
        if (bus.start && !done_q) begin
          rep_nxt   = (bus.redundancy == 8'd0) ? 8'd1 : bus.redundancy;
          id_nxt    = 8'd1;
          seg_nxt   = '0;
          fin_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        // Prime the one-cycle buffer read with byte 0.
        rd_seg_c     = seg;
        rd_idx_c     = '0;
        byte_cnt_nxt = '0;
        state_nxt    = SEND;
      end
      SEND: begin
        // Address of byte i+1 goes out while byte i is emitted.
        rd_seg_c = seg;
        rd_idx_c = byte_cnt + 16'd1;
        vld_p0   = 1'b1;
        data_p0  = frame_byte(byte_cnt, seg, id, aux_q, bus.rd_data);
        if (byte_cnt == LAST_BYTE) begin
          gap_cnt_nxt = '0;
          if (seg < LAST_SEG) begin
            seg_nxt   = seg + 16'd1;
            state_nxt = GAP;
          end else if (id < rep) begin
            seg_nxt   = '0;
            id_nxt    = id + 8'd1;
            state_nxt = RGAP;
          end else begin
            fin_nxt   = 1'b1;
            state_nxt = RGAP;
          end
        end else begin
          byte_cnt_nxt = byte_cnt + 16'd1;
        end
      end
      GAP: begin
        if (gap_cnt == IFG_LAST) state_nxt = FETCH;
        else                     gap_cnt_nxt = gap_cnt + 8'd1;
      end
      RGAP: begin
        if (gap_cnt == RGAP_LAST) begin
          if (fin) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            aux_nxt   = aux_q + 8'd1;
          end else begin
            state_nxt = FETCH;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: registered byte stream and status
  always_ff @(posedge clk125MHz) begin
    if (!reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      seg      <= '0;
      id       <= '0;
      fin      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      aux_q    <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      seg      <= seg_nxt;
      id       <= id_nxt;
      fin      <= fin_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      aux_q    <= aux_nxt;
      vld_p1   <= vld_p0;
      data_p1  <= data_p0;
    end
  end

  // Replica count is only consumed after it has been loaded by an accept.
  always_ff @(posedge clk125MHz) begin
    rep <= rep_nxt;
  end

  assign bus.rd_seg  = rd_seg_c;
  assign bus.rd_idx  = rd_idx_c;
  assign bus.tx_en   = vld_p1;
  assign bus.tx_data = data_p1;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.aux     = aux_q;
endmodule

// File: tb/tb_tx_redundant_framer.sv
// Testbench for tx_redundant_framer: a default-parameter instance for frame
// content/timing/reset scenarios and a short-frame instance for aux wrap.
module tb_tx_redundant_framer;
  logic clk = 1'b0;
  logic rst_n;
  always #4 clk = ~clk;

  tx_redundant_framer_if m_if ();
  tx_redundant_framer_if s_if ();

  tx_redundant_framer u_dut (
    .clk125MHz(clk),
    .reset    (rst_n),
    .bus      (m_if)
  );

  tx_redundant_framer #(
    .PACKET_SIZE        (8),
    .WHEREIS_SEGMENT_NUM(2),
    .SEGMENT_NUM_MAX    (1),
    .IFG                (1),
    .ROUND_GAP          (1)
  ) u_small (
    .clk125MHz(clk),
    .reset    (rst_n),
    .bus      (s_if)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Frame buffers: byte = (seg*16 + idx) & 0xFF, one cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_if.rd_data <= 8'((m_if.rd_seg << 4) + m_if.rd_idx);
    s_if.rd_data <= 8'((s_if.rd_seg << 4) + s_if.rd_idx);
  end

  // Main-instance frame recorder.
  logic [7:0] fr [0:63][0:599];
  int flen [0:63];
  int fgap [0:63];
  int fstart [0:63];
  int nfr = 0;
  int cur = 0;
  int low_run = 0;
  logic prev_en = 1'b0;
  int dn_cnt = 0;
  int done_cyc = 0;
  logic busy_at_done = 1'b0;
  logic [7:0] aux_at_done = 8'h00;

  always @(negedge clk) begin
    if (m_if.tx_en === 1'b1) begin
      if (!prev_en) begin
        if (nfr < 64) begin
          fgap[nfr] = low_run;
          fstart[nfr] = cyc;
        end
        cur = 0;
      end
      if (nfr < 64 && cur < 600) fr[nfr][cur] = m_if.tx_data;
      cur++;
      prev_en = 1'b1;
    end else begin
      if (prev_en) begin
        if (nfr < 64) flen[nfr] = cur;
        nfr++;
        low_run = 1;
      end else begin
        low_run++;
      end
      prev_en = 1'b0;
    end
    if (m_if.done === 1'b1) begin
      dn_cnt++;
      done_cyc = cyc;
      busy_at_done = m_if.busy;
      aux_at_done = m_if.aux;
    end
  end

  // Short-instance recorder: aux byte sits at index 5 of each 8-byte frame.
  logic [7:0] s_aux_seen [0:299];
  int s_cur = 0;
  int s_nfr = 0;

  always @(negedge clk) begin
    if (s_if.tx_en === 1'b1) begin
      if (s_cur == 5 && s_nfr < 300) s_aux_seen[s_nfr] = s_if.tx_data;
      s_cur++;
      if (s_cur == 8) begin
        s_cur = 0;
        s_nfr++;
      end
    end
  end

  task automatic pulse_main(input logic [7:0] r, output int acc);
    @(negedge clk);
    m_if.redundancy = r;
    m_if.start = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done_main(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (m_if.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (m_if.tx_en !== 1'b0) begin failures++; $display("FAIL reset_tx_en got=%b want=0", m_if.tx_en); end
    checks++; if (m_if.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h want=00", m_if.tx_data); end
    checks++; if (m_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", m_if.busy); end
    checks++; if (m_if.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", m_if.done); end
    checks++; if (m_if.aux !== 8'h00) begin failures++; $display("FAIL reset_aux got=%h want=00", m_if.aux); end
    checks++; if (m_if.rd_seg !== 16'h0 || m_if.rd_idx !== 16'h0) begin failures++; $display("FAIL reset_rd_addr got=%h/%h want=0/0", m_if.rd_seg, m_if.rd_idx); end
    checks++; if (s_if.busy !== 1'b0 || s_if.aux !== 8'h00) begin failures++; $display("FAIL reset_small got=%b/%h want=0/00", s_if.busy, s_if.aux); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_main_job();
    int base, dn0, acc, sg, idv, bad, last;
    bit ok;
    logic [7:0] e;
    base = nfr;
    dn0 = dn_cnt;
    pulse_main(8'd3, acc);
    checks++; if (m_if.busy !== 1'b1) begin failures++; $display("FAIL main_busy_after_accept got=%b want=1", m_if.busy); end
    wait_done_main(12000, ok);
    repeat (5) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL main_done_seen got=0 want=1"); end
    checks++; if (nfr - base != 15) begin failures++; $display("FAIL main_frame_count got=%0d want=15", nfr - base); end
    for (int f = 0; f < 15; f++) begin
      sg = f % 5;
      idv = f / 5 + 1;
      bad = 0;
      for (int i = 0; i < 577; i++) begin
        if (i == 34) e = 8'h00;
        else if (i == 35) e = 8'(sg);
        else if (i == 36) e = 8'(idv);
        else if (i == 37) e = 8'h00;
        else e = 8'((sg * 16 + i) & 255);
        if (fr[base + f][i] !== e) bad++;
      end
      checks++; if (bad != 0 || flen[base + f] != 577) begin failures++; $display("FAIL main_frame%0d bad_bytes=%0d len=%0d want 0/577", f, bad, flen[base + f]); end
    end
    checks++; if (fr[base + 8][34] !== 8'h00 || fr[base + 8][35] !== 8'h03 || fr[base + 8][36] !== 8'h02 || fr[base + 8][37] !== 8'h00)
      begin failures++; $display("FAIL id2s3_fields got=%h %h %h %h want=00 03 02 00", fr[base + 8][34], fr[base + 8][35], fr[base + 8][36], fr[base + 8][37]); end
    checks++; if (fr[base + 8][6] !== 8'h36) begin failures++; $display("FAIL id2s3_byte6 got=%h want=36", fr[base + 8][6]); end
    checks++; if (fgap[base + 1] != 11) begin failures++; $display("FAIL gap_s0_s1 got=%0d want=11", fgap[base + 1]); end
    checks++; if (fgap[base + 5] != 31) begin failures++; $display("FAIL gap_round got=%0d want=31", fgap[base + 5]); end
    checks++; if (fstart[base] - acc != 2) begin failures++; $display("FAIL first_byte_latency got=%0d want=2", fstart[base] - acc); end
    // R*N*P + R*(N-1)*(IFG+1) + R*(RG+1) + 1 = 8881 cycles counting both
    // the accept and done cycles, i.e. 8880 edges after the accept edge.
    checks++; if (done_cyc - acc != 8880) begin failures++; $display("FAIL job_length got=%0d want=8880", done_cyc - acc); end
    last = fstart[base + 14] + 576;
    checks++; if (done_cyc - last != 30) begin failures++; $display("FAIL done_after_last_byte got=%0d want=30", done_cyc - last); end
    checks++; if (busy_at_done !== 1'b0 || aux_at_done !== 8'h01) begin failures++; $display("FAIL done_cycle_status busy=%b aux=%h want 0/01", busy_at_done, aux_at_done); end
    checks++; if (dn_cnt - dn0 != 1) begin failures++; $display("FAIL main_done_count got=%0d want=1", dn_cnt - dn0); end
    checks++; if (m_if.aux !== 8'h01) begin failures++; $display("FAIL main_aux_after got=%h want=01", m_if.aux); end
  endtask

  task automatic test_redundancy_zero();
    int base, acc, bad;
    bit ok;
    base = nfr;
    pulse_main(8'd0, acc);
    wait_done_main(5000, ok);
    repeat (5) @(negedge clk);
    checks++; if (!ok || nfr - base != 5) begin failures++; $display("FAIL r0_frame_count got=%0d want=5", nfr - base); end
    bad = 0;
    for (int f = 0; f < 5; f++) begin
      if (fr[base + f][36] !== 8'h01 || fr[base + f][37] !== 8'h01 || fr[base + f][35] !== 8'(f)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL r0_fields bad_frames=%0d want=0", bad); end
    checks++; if (m_if.aux !== 8'h02) begin failures++; $display("FAIL r0_aux_after got=%h want=02", m_if.aux); end
  endtask

  task automatic test_ignored_start();
    int base, dn0, acc, bad;
    bit ok;
    base = nfr;
    dn0 = dn_cnt;
    pulse_main(8'd1, acc);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (nfr == base + 1 && m_if.tx_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin failures++; $display("FAIL ign_reach_frame2 got=0 want=1"); end
    repeat (20) @(negedge clk);
    m_if.redundancy = 8'd7;
    m_if.start = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
    wait_done_main(5000, ok);
    // start held high through the done cycle itself
    m_if.start = 1'b1;
    @(negedge clk);
    m_if.start = 1'b0;
    repeat (40) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL ign_done_seen got=0 want=1"); end
    checks++; if (nfr - base != 5) begin failures++; $display("FAIL ign_frame_count got=%0d want=5", nfr - base); end
    checks++; if (m_if.busy !== 1'b0) begin failures++; $display("FAIL ign_busy_after got=%b want=0", m_if.busy); end
    checks++; if (dn_cnt - dn0 != 1) begin failures++; $display("FAIL ign_done_count got=%0d want=1", dn_cnt - dn0); end
    bad = 0;
    for (int f = 0; f < 5; f++) begin
      if (flen[base + f] != 577 || fr[base + f][35] !== 8'(f) || fr[base + f][36] !== 8'h01 ||
          fr[base + f][37] !== 8'h02 || fr[base + f][100] !== 8'((f * 16 + 100) & 255)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL ign_contents bad_frames=%0d want=0", bad); end
    checks++; if (m_if.aux !== 8'h03) begin failures++; $display("FAIL ign_aux_after got=%h want=03", m_if.aux); end
  endtask

  task automatic test_aux_wrap();
    int base, miss, bad;
    bit got;
    base = s_nfr;
    miss = 0;
    s_if.redundancy = 8'd1;
    for (int j = 0; j < 257; j++) begin
      @(negedge clk);
      s_if.start = 1'b1;
      @(negedge clk);
      s_if.start = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (s_if.done === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) miss++;
    end
    repeat (2) @(negedge clk);
    checks++; if (miss != 0) begin failures++; $display("FAIL wrap_jobs_missing got=%0d want=0", miss); end
    checks++; if (s_nfr - base != 257) begin failures++; $display("FAIL wrap_frame_count got=%0d want=257", s_nfr - base); end
    bad = 0;
    for (int j = 0; j < 257; j++) begin
      if (base + j < 300) begin
        if (s_aux_seen[base + j] !== 8'(j)) bad++;
      end
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_aux_sequence bad_jobs=%0d want=0", bad); end
    checks++; if (s_aux_seen[base + 255] !== 8'hFF) begin failures++; $display("FAIL wrap_job256_aux got=%h want=ff", s_aux_seen[base + 255]); end
    checks++; if (s_aux_seen[base + 256] !== 8'h00) begin failures++; $display("FAIL wrap_job257_aux got=%h want=00", s_aux_seen[base + 256]); end
    checks++; if (s_if.aux !== 8'h01) begin failures++; $display("FAIL wrap_aux_after got=%h want=01", s_if.aux); end
  endtask

  task automatic test_reset_midframe();
    int base, base2, acc;
    bit ok;
    base = nfr;
    pulse_main(8'd1, acc);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (nfr == base + 3 && m_if.tx_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rst_reach_frame4 got=0 want=1"); end
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (m_if.tx_en !== 1'b0 || m_if.busy !== 1'b0 || m_if.aux !== 8'h00)
      begin failures++; $display("FAIL rst_mid_status tx_en=%b busy=%b aux=%h want 0/0/00", m_if.tx_en, m_if.busy, m_if.aux); end
    checks++; if (m_if.tx_data !== 8'h00 || m_if.done !== 1'b0 || m_if.rd_seg !== 16'h0 || m_if.rd_idx !== 16'h0)
      begin failures++; $display("FAIL rst_mid_outputs data=%h done=%b seg=%h idx=%h want 00/0/0/0", m_if.tx_data, m_if.done, m_if.rd_seg, m_if.rd_idx); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (flen[base + 3] != 101) begin failures++; $display("FAIL rst_truncated_len got=%0d want=101", flen[base + 3]); end
    base2 = nfr;
    pulse_main(8'd1, acc);
    ok = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (nfr > base2) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok || flen[base2] != 577) begin failures++; $display("FAIL replay_frame_len got=%0d want=577", flen[base2]); end
    checks++; if (fr[base2][34] !== 8'h00 || fr[base2][35] !== 8'h00 || fr[base2][36] !== 8'h01 || fr[base2][37] !== 8'h00)
      begin failures++; $display("FAIL replay_fields got=%h %h %h %h want=00 00 01 00", fr[base2][34], fr[base2][35], fr[base2][36], fr[base2][37]); end
    checks++; if (fr[base2][6] !== 8'h06 || fr[base2][200] !== 8'hC8) begin failures++; $display("FAIL replay_payload got=%h/%h want=06/c8", fr[base2][6], fr[base2][200]); end
    checks++; if (fstart[base2] - acc != 2) begin failures++; $display("FAIL replay_latency got=%0d want=2", fstart[base2] - acc); end
  endtask

  initial begin
    rst_n = 1'b0;
    m_if.start = 1'b0;
    m_if.redundancy = 8'd0;
    s_if.start = 1'b0;
    s_if.redundancy = 8'd1;
    test_reset();
    test_main_job();
    test_redundancy_zero();
    test_ignored_start();
    test_aux_wrap();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
